// File: rtl/dvs_ravens_pkg.sv
// Shared types and limits for the RAVENS-side bus infrastructure.
// The bus arbiter imports these types and limits.
package dvs_ravens_pkg;

    typedef enum logic {ARB_FIXED, ARB_RR} arb_mode_e;
    typedef enum logic {ARB_IDLE, ARB_OWNED} arb_state_e;

    localparam int ARB_MAX_REQ = 16;

    // Index width for an n-entry requester vector; never narrower than one bit.
    function automatic int arb_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dvs_ravens_prio_enc.sv
// Rotating, maskable priority encoder: the first set bit of (vec & ~excl),
// searching upward from start and wrapping from N-1 back to 0.
module dvs_ravens_prio_enc #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  vec,
    input  logic [IW-1:0] start,
    input  logic [N-1:0]  excl,
    output logic          found,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx
);

    logic [N-1:0] masked;

    assign masked = vec & ~excl;

    always_comb begin
        int j;
        found  = 1'b0;
        onehot = '0;
        idx    = '0;
        j      = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(start) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!found && masked[j]) begin
                found     = 1'b1;
                onehot[j] = 1'b1;
                idx       = IW'(j);
            end
        end
    end

endmodule

// File: rtl/dvs_ravens_rr_arbiter.sv
// N-master bus arbiter for the RAVENS-side bus: fixed or rotating priority,
// registered one-hot grant held per transaction, optional hold timeout.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   ARB_IDLE  | no owner; any request is granted at the next edge
//   ARB_OWNED | one grant bit set; held until release or hold timeout
module dvs_ravens_rr_arbiter
    import dvs_ravens_pkg::*;
#(
    parameter int        NUM_REQ  = 4,
    parameter arb_mode_e ARB_MODE = ARB_RR,
    parameter int        MAX_HOLD = 0,
    localparam int       IDX_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic               grant_valid,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               preempt
);

    arb_state_e         state;
    arb_state_e         state_nxt;
    logic [NUM_REQ-1:0] grant_nxt;
    logic [IDX_W-1:0]   idx_nxt;
    logic               preempt_nxt;
    logic               new_grant;

    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   rr_ptr_nxt;
    logic [IDX_W-1:0]   search_start;
    logic [NUM_REQ-1:0] excl;

    logic               win_found;
    logic [NUM_REQ-1:0] win_onehot;
    logic [IDX_W-1:0]   win_idx;

    logic               owner_req;
    logic               other_pending;
    logic               hold_expired;

    assign owner_req     = |(req & grant);
    assign other_pending = |(req & ~grant);

    // Only a timed-out owner is masked; a releasing owner has req low anyway.
    assign excl         = (state == ARB_OWNED && hold_expired) ? grant : '0;
    assign search_start = (ARB_MODE == ARB_RR) ? rr_ptr : '0;
    assign rr_ptr_nxt   = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);

    dvs_ravens_prio_enc #(
        .N  (NUM_REQ),
        .IW (IDX_W)
    ) u_prio_enc (
        .vec    (req),
        .start  (search_start),
        .excl   (excl),
        .found  (win_found),
        .onehot (win_onehot),
        .idx    (win_idx)
    );

    always_comb begin
        state_nxt   = state;
        grant_nxt   = grant;
        idx_nxt     = grant_idx;
        preempt_nxt = 1'b0;
        new_grant   = 1'b0;

        case (state)
            ARB_IDLE: begin
                if (win_found) begin
                    new_grant = 1'b1;
                end
            end
            ARB_OWNED: begin
                // Release wins over timeout when both land on the same edge.
                if (!owner_req) begin
                    if (win_found) begin
                        new_grant = 1'b1;
                    end else begin
                        state_nxt = ARB_IDLE;
                        grant_nxt = '0;
                        idx_nxt   = '0;
                    end
                end else if (hold_expired && other_pending) begin
                    new_grant   = 1'b1;
                    preempt_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = ARB_IDLE;
                grant_nxt = '0;
                idx_nxt   = '0;
            end
        endcase

        if (new_grant) begin
            state_nxt = ARB_OWNED;
            grant_nxt = win_onehot;
            idx_nxt   = win_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ARB_IDLE;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_idx   <= '0;
            preempt     <= 1'b0;
        end else begin
            state       <= state_nxt;
            grant       <= grant_nxt;
            grant_valid <= |grant_nxt;
            grant_idx   <= idx_nxt;
            preempt     <= preempt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (new_grant) begin
            rr_ptr <= rr_ptr_nxt;
        end
    end

    generate
        if (MAX_HOLD > 0) begin : g_hold
            localparam int HOLD_W = $clog2(MAX_HOLD + 1);

            logic [HOLD_W-1:0] hold_cnt;

            assign hold_expired = (hold_cnt == HOLD_W'(MAX_HOLD - 1));

            // Saturates at MAX_HOLD-1 so a lone owner keeps its grant indefinitely.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    hold_cnt <= '0;
                end else if (new_grant) begin
                    hold_cnt <= '0;
                end else if (state == ARB_OWNED && !hold_expired) begin
                    hold_cnt <= hold_cnt + HOLD_W'(1);
                end
            end
        end else begin : g_no_hold
            assign hold_expired = 1'b0;
        end
    endgenerate

endmodule
